// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} hz_state_t;
   localparam logic [4:0] XZR = 5'd31;
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter; holds at all-ones once full.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                   count <= '0;
      else if (inc && count != '1)  count <= count + 1'b1;
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock,
// taken-branch squash and data-memory wait, with saturating perf counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LU_CYCLES   = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   input  logic             uses_rs2_id,
   input  logic             MemRead_ex,
   input  logic [4:0]       Rd_ex,
   input  logic             BrTaken_mem,
   input  logic             dm_req_mem,
   input  logic             dm_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int LU_W  = $clog2(LU_CYCLES + 1);
   localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [LU_W-1:0]  LU_LOAD = LU_W'(LU_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

   hz_state_t        r_state, w_state_nxt;
   logic [LU_W-1:0]  r_lu_cnt, w_lu_cnt_nxt;
   logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
   logic             r_mem_err;

   logic w_lu_hz, w_mw_hz, w_run, w_wait_cyc, w_br_svc;
   logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
   logic w_exmem_en, w_exmem_flush, w_memwb_flush;

   assign w_lu_hz = MemRead_ex && (Rd_ex != XZR) &&
                    ((rs1_id == Rd_ex) || (uses_rs2_id && (rs2_id == Rd_ex)));
   assign w_mw_hz = dm_req_mem && !dm_ready;

   always_comb begin
      w_pc_en       = 1'b1;
      w_ifid_en     = 1'b1;
      w_ifid_flush  = 1'b0;
      w_idex_en     = 1'b1;
      w_idex_flush  = 1'b0;
      w_exmem_en    = 1'b1;
      w_exmem_flush = 1'b0;
      w_memwb_flush = 1'b0;
      w_state_nxt   = r_state;
      w_lu_cnt_nxt  = r_lu_cnt;
      w_tmo_nxt     = r_tmo_cnt;
      w_run         = 1'b0;
      w_wait_cyc    = 1'b0;
      w_br_svc      = 1'b0;

      case (r_state)
         MEM_WAIT: begin
            if (!dm_ready) begin
               w_wait_cyc = 1'b1;
               w_tmo_nxt  = (r_tmo_cnt == TMO_MAX) ? r_tmo_cnt : r_tmo_cnt + 1'b1;
            end else begin
               w_run = 1'b1;
            end
         end
         LU_STALL: begin
            if (w_mw_hz) begin
               w_wait_cyc  = 1'b1;
               w_tmo_nxt   = TMO_W'(1);
               w_state_nxt = MEM_WAIT;
            end else begin
               w_pc_en      = 1'b0;
               w_ifid_en    = 1'b0;
               w_idex_flush = 1'b1;
               w_lu_cnt_nxt = r_lu_cnt - 1'b1;
               if (r_lu_cnt == LU_W'(1)) w_state_nxt = RUN;
            end
         end
         default: w_run = 1'b1;
      endcase

      // Shared by RUN and the dm_ready cycle of MEM_WAIT (mw_hz is false there).
      if (w_run) begin
         w_state_nxt = RUN;
         if (w_mw_hz) begin
            w_wait_cyc  = 1'b1;
            w_tmo_nxt   = TMO_W'(1);
            w_state_nxt = MEM_WAIT;
         end else if (BrTaken_mem) begin
            w_br_svc      = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
         end else if (w_lu_hz) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
            w_lu_cnt_nxt = LU_LOAD;
            w_state_nxt  = (LU_CYCLES > 1) ? LU_STALL : RUN;
         end
      end

      if (w_wait_cyc) begin
         w_pc_en       = 1'b0;
         w_ifid_en     = 1'b0;
         w_idex_en     = 1'b0;
         w_exmem_en    = 1'b0;
         w_memwb_flush = 1'b1;
      end

      if (!reset) begin
         w_pc_en       = 1'b0;
         w_ifid_en     = 1'b0;
         w_idex_en     = 1'b0;
         w_exmem_en    = 1'b0;
         w_ifid_flush  = 1'b1;
         w_idex_flush  = 1'b1;
         w_exmem_flush = 1'b1;
         w_memwb_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= RUN;
         r_lu_cnt  <= '0;
         r_tmo_cnt <= '0;
         r_mem_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_lu_cnt  <= w_lu_cnt_nxt;
         r_tmo_cnt <= w_tmo_nxt;
         if (w_wait_cyc && (w_tmo_nxt == TMO_MAX)) r_mem_err <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk(clk), .reset(reset), .inc(!w_pc_en), .count(stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .reset(reset), .inc(w_br_svc), .count(flush_cnt)
   );

   assign pc_en       = w_pc_en;
   assign ifid_en     = w_ifid_en;
   assign ifid_flush  = w_ifid_flush;
   assign idex_en     = w_idex_en;
   assign idex_flush  = w_idex_flush;
   assign exmem_en    = w_exmem_en;
   assign exmem_flush = w_exmem_flush;
   assign memwb_flush = w_memwb_flush;
   assign mem_err     = r_mem_err;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + short random bench for pipe_hazard_ctrl against a per-cycle behavioural model.
module tb_pipe_hazard_ctrl;
   localparam int LU  = 2;
   localparam int TMO = 4;
   localparam int CW  = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0, reset;
   logic [4:0] rs1_id, rs2_id, Rd_ex;
   logic uses_rs2_id, MemRead_ex, BrTaken_mem, dm_req_mem, dm_ready;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_chk = 0, n_pass = 0;

   pipe_hazard_ctrl #(.LU_CYCLES(LU), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs2_id(uses_rs2_id),
      .MemRead_ex(MemRead_ex), .Rd_ex(Rd_ex), .BrTaken_mem(BrTaken_mem), .dm_req_mem(dm_req_mem),
      .dm_ready(dm_ready), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
      .memwb_flush(memwb_flush), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
   endtask

   // Model state: waiting on memory, cycles waited, remaining load-use bubbles, counters, error flag.
   bit m_wait = 0, n_wait = 0, m_err = 0, n_err = 0;
   int m_waited = 0, n_waited = 0, m_lu_left = 0, n_lu_left = 0;
   int m_stall = 0, n_stall = 0, m_flush = 0, n_flush = 0;

   always @(negedge clk) begin
      logic [8:0] e, a;   // {pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb_fl,err}
      bit lu, mw;
      int es, ef;
      a = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush, mem_err};
      if (!reset) begin
         e = 9'b0_0_1_0_1_0_1_1_0; es = 0; ef = 0;
         n_wait = 0; n_waited = 0; n_lu_left = 0; n_stall = 0; n_flush = 0; n_err = 0;
      end else begin
         lu = MemRead_ex && Rd_ex != 5'd31 && (rs1_id == Rd_ex || (uses_rs2_id && rs2_id == Rd_ex));
         mw = dm_req_mem && !dm_ready;
         es = m_stall; ef = m_flush;
         n_wait = 0; n_waited = m_waited; n_lu_left = m_lu_left;
         n_stall = m_stall; n_flush = m_flush; n_err = m_err;
         e = {8'b1_1_0_1_0_1_0_0, m_err};
         if (m_wait ? !dm_ready : mw) begin
            e[8:1] = 8'b0_0_0_0_0_0_0_1;
            n_wait = 1; n_lu_left = 0;
            n_waited = m_wait ? ((m_waited + 1 > TMO) ? TMO : m_waited + 1) : 1;
            if (n_waited >= TMO) n_err = 1;
         end else if (m_lu_left > 0) begin
            e[8:1] = 8'b0_0_0_1_1_1_0_0;
            n_lu_left = m_lu_left - 1;
         end else if (BrTaken_mem) begin
            e[8:1] = 8'b1_1_1_1_1_1_1_0;
            n_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
         end else if (lu) begin
            e[8:1] = 8'b0_0_0_1_1_1_0_0;
            n_lu_left = LU - 1;
         end
         if (!e[8]) n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
      chk("ctl", 32'(a), 32'(e));
      chk("stall_cnt", 32'(stall_cnt), es);
      chk("flush_cnt", 32'(flush_cnt), ef);
   end

   always @(posedge clk) begin
      m_wait = n_wait; m_waited = n_waited; m_lu_left = n_lu_left;
      m_stall = n_stall; m_flush = n_flush; m_err = n_err;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      rs1_id = 5'd1; rs2_id = 5'd2; uses_rs2_id = 1'b0; MemRead_ex = 1'b0; Rd_ex = 5'd3;
      BrTaken_mem = 1'b0; dm_req_mem = 1'b0; dm_ready = 1'b1;
   endtask

   task automatic load_use(input logic [4:0] r);
      MemRead_ex = 1'b1; Rd_ex = r; rs1_id = r;
   endtask

   initial begin
      reset = 1'b0; idle();
      #1;
      chk("rst_pc_en", 32'(pc_en), 0);
      chk("rst_memwb_flush", 32'(memwb_flush), 1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      tick();

      // load into XZR never interlocks
      MemRead_ex = 1'b1; Rd_ex = 5'd31; rs1_id = 5'd31; rs2_id = 5'd31; uses_rs2_id = 1'b1;
      #1 chk("xzr_pc_en", 32'(pc_en), 1);
      tick(); idle();

      // load-use, two bubbles
      load_use(5'd5);
      #1 chk("lu1_pc_en", 32'(pc_en), 0);
      chk("lu1_idex_flush", 32'(idex_flush), 1);
      tick(); idle();
      #1 chk("lu2_pc_en", 32'(pc_en), 0);
      chk("lu2_idex_flush", 32'(idex_flush), 1);
      tick();
      #1 chk("lu_done_pc_en", 32'(pc_en), 1);
      chk("lu_stall_cnt", 32'(stall_cnt), 2);

      // rs2 match only counts when rs2 is read
      MemRead_ex = 1'b1; Rd_ex = 5'd7; rs1_id = 5'd3; rs2_id = 5'd7; uses_rs2_id = 1'b0;
      #1 chk("rs2_unused_pc_en", 32'(pc_en), 1);
      tick();
      uses_rs2_id = 1'b1;
      #1 chk("rs2_used_pc_en", 32'(pc_en), 0);
      tick(); idle(); tick();
      chk("rs2_stall_cnt", 32'(stall_cnt), 4);

      // taken branch squashes a coincident load-use
      load_use(5'd9); BrTaken_mem = 1'b1;
      #1 chk("br_pc_en", 32'(pc_en), 1);
      chk("br_flushes", 32'({ifid_flush, idex_flush, exmem_flush}), 32'h7);
      tick(); idle();
      #1 chk("br_flush_cnt", 32'(flush_cnt), 1);
      chk("br_stall_cnt", 32'(stall_cnt), 4);

      // three-cycle memory wait
      dm_req_mem = 1'b1; dm_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("mw_memwb_flush", 32'(memwb_flush), 1);
         tick();
      end
      dm_ready = 1'b1;
      #1 chk("mw_resume_pc_en", 32'(pc_en), 1);
      chk("mw_resume_memwb", 32'(memwb_flush), 0);
      tick(); idle();
      chk("mw_stall_cnt", 32'(stall_cnt), 7);
      chk("mw_no_err", 32'(mem_err), 0);

      // timeout, then branch serviced on the ready cycle
      dm_req_mem = 1'b1; dm_ready = 1'b0; BrTaken_mem = 1'b1;
      repeat (3) tick();
      chk("tmo_err_early", 32'(mem_err), 0);
      tick();
      chk("tmo_err_set", 32'(mem_err), 1);
      repeat (2) tick();
      dm_ready = 1'b1;
      #1 chk("tmo_br_exmem_flush", 32'(exmem_flush), 1);
      tick(); idle();
      chk("tmo_err_sticky", 32'(mem_err), 1);
      chk("tmo_flush_cnt", 32'(flush_cnt), 2);
      chk("tmo_stall_cnt", 32'(stall_cnt), 13);

      // memory wait preempts a load-use stall; counter saturates
      load_use(5'd4);
      tick(); idle();
      dm_req_mem = 1'b1; dm_ready = 1'b0;
      #1 chk("pre_memwb_flush", 32'(memwb_flush), 1);
      tick();
      dm_ready = 1'b1;
      tick(); idle();
      load_use(5'd6);
      tick(); idle(); tick();
      chk("sat_stall_cnt", 32'(stall_cnt), CMAX);

      for (int i = 0; i < 300; i++) begin
         Rd_ex = 5'($urandom_range(28, 31)); rs1_id = 5'($urandom_range(28, 31));
         rs2_id = 5'($urandom_range(28, 31)); uses_rs2_id = 1'($urandom_range(0, 1));
         MemRead_ex = 1'($urandom_range(0, 1)); BrTaken_mem = ($urandom_range(0, 7) == 0);
         dm_req_mem = ($urandom_range(0, 3) == 0); dm_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      idle(); tick();

      // reset while frozen on memory
      dm_req_mem = 1'b1; dm_ready = 1'b0;
      tick();
      reset = 1'b0;
      #1 chk("rst_mid_en", 32'({pc_en, ifid_en, idex_en, exmem_en}), 0);
      chk("rst_mid_flush", 32'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'hf);
      chk("rst_mid_cnt", 32'({stall_cnt, flush_cnt}), 0);
      chk("rst_mid_err", 32'(mem_err), 0);
      tick(); idle(); reset = 1'b1;
      #1 chk("rst_rel_pc_en", 32'(pc_en), 1);
      chk("rst_rel_stall_cnt", 32'(stall_cnt), 0);
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
